// File: rtl/core_pkg.sv
// Shared core types and widths: hazard FSM states, register index width and
// counter widths used by the hazard controller.
package core_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_e;

  localparam int REG_W  = 5;
  localparam int BCNT_W = 3;
  localparam int WAIT_W = 8;
  localparam int PERF_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall-cycle and redirect counters for the hazard controller; instantiated
// only when HAZARD_PERF_CNT_EN is defined. Both counters wrap modulo 2^32.
module hazard_perf_cnt
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [PERF_W-1:0] o_stall_cnt,
  output logic [PERF_W-1:0] o_flush_cnt
);

  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (i_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller beside ID: dmem freeze > branch redirect > load-use
// stall > fetch wait. Optional perf counters under macro HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              branch_taken,
  input  logic              imem_ready,
  input  logic              mem_req,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_write,
  output logic              idex_flush,
  output logic              exmem_write,
  output logic              memwb_flush,
  output logic              mem_timeout_err,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  localparam logic [0:0]        S_RUN      = 1'(RUN);
  localparam logic [0:0]        S_LU       = 1'(LU_STALL);
  localparam logic [BCNT_W-1:0] BUBBLES_M1 = BCNT_W'(LOAD_USE_BUBBLES - 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(MEM_TIMEOUT - 1);

  logic [0:0]        r_state;
  logic [BCNT_W-1:0] r_bcnt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_err;

  logic w_busy;
  logic w_freeze;
  logic w_in_run;
  logic w_load_use;
  logic w_branch_act;
  logic w_lu_act;

  assign w_busy   = mem_req & ~dmem_ready;
  // Once timed out the pipeline stays frozen until reset, even if dmem recovers.
  assign w_freeze = w_busy | r_err;
  assign w_in_run = (r_state == S_RUN);

  assign w_load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

  assign w_branch_act = ~w_freeze & w_in_run & branch_taken;
  assign w_lu_act     = ~w_freeze & ~w_branch_act & (w_load_use | ~w_in_run);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    memwb_flush = 1'b0;
    if (w_freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else if (w_branch_act) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_lu_act) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_write   = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // The RUN cycle that detects the hazard is the first bubble; LU_STALL adds the rest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
      r_bcnt  <= '0;
    end else if (!w_freeze) begin
      if (w_in_run) begin
        if (w_load_use && !branch_taken && (LOAD_USE_BUBBLES > 1)) begin
          r_state <= S_LU;
          r_bcnt  <= BUBBLES_M1;
        end
      end else begin
        r_bcnt <= r_bcnt - 1'b1;
        if (r_bcnt == BCNT_W'(1)) r_state <= S_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      if (!w_busy)          r_wait <= '0;
      else if (r_wait != '1) r_wait <= r_wait + 1'b1;
      if (w_busy && (r_wait == TIMEOUT_M1)) r_err <= 1'b1;
    end
  end

  assign mem_timeout_err = r_err;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf (
    .clk         (clk),
    .reset       (reset),
    .i_stall     (~pc_write),
    .i_flush     (w_branch_act),
    .o_stall_cnt (perf_stall_cnt),
    .o_flush_cnt (perf_flush_cnt)
  );
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

`ifndef SYNTHESIS
  a_no_branch_in_stall: assert property (@(posedge clk) disable iff (reset)
    !((r_state == S_LU) && branch_taken))
    else $error("branch_taken asserted while in load-use stall");
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 bubble / timeout 255, 3 bubbles /
// timeout 10) share stimulus and are checked against a cycle-level model.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, branch_taken = 0;
  logic       imem_ready = 1, mem_req = 0, dmem_ready = 1;

  logic [1:0]  pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic [1:0]  exmem_write, memwb_flush, mem_timeout_err;
  logic [31:0] perf_stall [2];
  logic [31:0] perf_flush [2];

  int errors = 0;
  int checks = 0;

  int B [2]  = '{1, 3};
  int MT [2] = '{255, 10};
  int m_left [2];
  int m_wait [2];
  bit m_err [2];
  int m_stl [2];
  int m_fl [2];
  int n_pc0 [2];
  int n_frz [2];

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(255)) u_dut1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .branch_taken(branch_taken), .imem_ready(imem_ready),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .pc_write(pc_write[0]),
    .ifid_write(ifid_write[0]), .ifid_flush(ifid_flush[0]), .idex_write(idex_write[0]),
    .idex_flush(idex_flush[0]), .exmem_write(exmem_write[0]), .memwb_flush(memwb_flush[0]),
    .mem_timeout_err(mem_timeout_err[0]), .perf_stall_cnt(perf_stall[0]),
    .perf_flush_cnt(perf_flush[0]));

  hazard_ctrl #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(10)) u_dut3 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .branch_taken(branch_taken), .imem_ready(imem_ready),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .pc_write(pc_write[1]),
    .ifid_write(ifid_write[1]), .ifid_flush(ifid_flush[1]), .idex_write(idex_write[1]),
    .idex_flush(idex_flush[1]), .exmem_write(exmem_write[1]), .memwb_flush(memwb_flush[1]),
    .mem_timeout_err(mem_timeout_err[1]), .perf_stall_cnt(perf_stall[1]),
    .perf_flush_cnt(perf_flush[1]));

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_load_use();
    return ex_mem_read && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit frozen(int k);
    return (mem_req && !dmem_ready) || m_err[k];
  endfunction

  function automatic bit branch_acted(int k);
    return !frozen(k) && (m_left[k] == 0) && branch_taken;
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush}
  function automatic logic [6:0] model_out(int k);
    if (frozen(k))                          return 7'b0000001;
    if (branch_acted(k))                    return 7'b1111110;
    if (is_load_use() || m_left[k] > 0)     return 7'b0001110;
    if (!imem_ready)                        return 7'b0111010;
    return 7'b1101010;
  endfunction

  task automatic cmp(string tag);
    logic [6:0] o;
    for (int k = 0; k < 2; k++) begin
      o = {pc_write[k], ifid_write[k], ifid_flush[k], idex_write[k],
           idex_flush[k], exmem_write[k], memwb_flush[k]};
      check($sformatf("%s.u%0d.ctl", tag, k), 32'(o), 32'(model_out(k)));
      check($sformatf("%s.u%0d.err", tag, k), 32'(mem_timeout_err[k]), 32'(m_err[k]));
      check($sformatf("%s.u%0d.pstl", tag, k), perf_stall[k], PERF_ON ? m_stl[k] : 0);
      check($sformatf("%s.u%0d.pfl", tag, k), perf_flush[k], PERF_ON ? m_fl[k] : 0);
      if (!pc_write[k])   n_pc0[k]++;
      if (memwb_flush[k]) n_frz[k]++;
    end
  endtask

  task automatic model_clock();
    bit busy, lu;
    busy = mem_req && !dmem_ready;
    lu   = is_load_use();
    for (int k = 0; k < 2; k++) begin
      if (model_out(k)[6] == 1'b0) m_stl[k]++;
      if (branch_acted(k))         m_fl[k]++;
      if (!frozen(k)) begin
        if (m_left[k] > 0)           m_left[k]--;
        else if (lu && !branch_taken) m_left[k] = B[k] - 1;
      end
      if (busy) begin
        if (m_wait[k] < 255) m_wait[k]++;
        if (m_wait[k] >= MT[k]) m_err[k] = 1'b1;
      end else begin
        m_wait[k] = 0;
      end
    end
  endtask

  task automatic cycle(string tag);
    #1 cmp(tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic apply_reset(string tag);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_wait[k] = 0; m_err[k] = 0; m_stl[k] = 0; m_fl[k] = 0;
    end
    #2 cmp(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0;
    ex_rd = 0; branch_taken = 0; imem_ready = 1; mem_req = 0; dmem_ready = 1;
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 2; k++) begin n_pc0[k] = 0; n_frz[k] = 0; end
  endtask

  initial begin
    idle();
    apply_reset("reset");

    // Load-use on rs1 = x5: one stall for 1 bubble, three for 3 bubbles.
    clr_counts();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    cycle("lu_first");
    ex_mem_read = 0;
    for (int i = 0; i < 4; i++) cycle("lu_tail");
    check("lu_len_b1", 32'(n_pc0[0]), 32'd1);
    check("lu_len_b3", 32'(n_pc0[1]), 32'd3);

    // Branch together with load-use: redirect, no stall afterwards.
    idle(); clr_counts();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; branch_taken = 1;
    #1 check("br_lu_pc", 32'(pc_write[1]), 32'd1);
    check("br_lu_flush", 32'({ifid_flush[1], idex_flush[1]}), 32'd3);
    cycle("br_lu");
    idle();
    cycle("br_after");
    check("br_no_stall", 32'(n_pc0[1]), 32'd0);

    // Freeze 4 cycles in the middle of a 3-bubble stall.
    idle(); clr_counts();
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    cycle("frz_lu");
    idle(); mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) cycle("frz_busy");
    dmem_ready = 1;
    for (int i = 0; i < 3; i++) cycle("frz_resume");
    check("frz_cycles", 32'(n_frz[1]), 32'd4);
    check("frz_stall_total", 32'(n_pc0[1]), 32'd7);

    // Timeout after 10 consecutive busy cycles on the 3-bubble instance.
    idle(); mem_req = 1; dmem_ready = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle("tmo_busy");
      if (i == 9)  check("tmo_before", 32'(mem_timeout_err[1]), 32'd0);
      if (i == 10) check("tmo_rise", 32'(mem_timeout_err[1]), 32'd1);
    end
    dmem_ready = 1;
    cycle("tmo_sticky");
    check("tmo_stays", 32'(mem_timeout_err[1]), 32'd1);
    dmem_ready = 0;
    #3 apply_reset("tmo_reset");
    check("tmo_cleared", 32'(mem_timeout_err[1]), 32'd0);

    // x0 never creates a hazard; fetch wait alone.
    idle();
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1 check("x0_no_stall", 32'(pc_write[0]), 32'd1);
    cycle("x0");
    idle(); imem_ready = 0;
    #1 check("imem_wait", 32'({pc_write[0], ifid_flush[0], idex_write[0]}), 32'b011);
    cycle("imem");

    // Randomized traffic; branches only when the 3-bubble instance is in RUN.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin idle(); apply_reset("rnd_reset"); end
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      branch_taken = (m_left[1] == 0) && ($urandom_range(0, 6) == 0);
      imem_ready   = ($urandom_range(0, 4) != 0);
      mem_req      = ($urandom_range(0, 4) == 0);
      dmem_ready   = 1'($urandom_range(0, 1));
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Sequences the IF/ID pipeline register and the stages around it: PC write enable, IF/ID write and flush, ID/EX write and flush, EX/MEM write, MEM/WB bubble.
- Resolves load-use stalls (multi-cycle), taken-branch redirects, instruction-fetch wait and data-memory wait, with a fixed priority.
- Sits beside the ID stage; takes decoded register indices from IF/ID and status from EX/MEM.

Parameters:
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..7).
- MEM_TIMEOUT, 255, consecutive dmem-wait cycles before timeout error (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- id_rs1  in  5  ID source register 1 (from IF/ID read_reg1)
- id_rs2  in  5  ID source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- branch_taken  in  1  EX resolved taken branch/jump
- imem_ready  in  1  fetch word for current PC valid
- mem_req  in  1  MEM stage issues a data access
- dmem_ready  in  1  data access completes this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to zero (NOP)
- idex_write  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX clear (bubble)
- exmem_write  out  1  EX/MEM load enable
- memwb_flush  out  1  MEM/WB bubble
- mem_timeout_err  out  1  sticky dmem timeout flag
- perf_stall_cnt  out  32  stall-cycle count (optional feature)
- perf_flush_cnt  out  32  redirect count (optional feature)

Behaviour:
- Definitions:
  - load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - dmem_busy = mem_req & !dmem_ready.
- Default outputs (no hazard): pc_write=1, ifid_write=1, idex_write=1, exmem_write=1, all flushes 0.
- Outputs are combinational from state and inputs. State, counters and the error flag are registered.
- FSM states: RUN and LU_STALL. A 3-bit bubble counter bcnt is used in LU_STALL.
- Priority in every cycle, highest first:
  1. dmem_busy: freeze. pc_write, ifid_write, idex_write and exmem_write are 0; all flushes are 0 except memwb_flush=1. FSM state and bcnt hold.
  2. branch_taken (RUN only): pc_write=1, ifid_flush=1, idex_flush=1; load_use is ignored.
  3. load_use, or state LU_STALL: pc_write=0, ifid_write=0, idex_flush=1.
  4. !imem_ready: pc_write=0, ifid_flush=1; downstream stages advance.
- Load-use with imem_ready=0 in the same cycle: load-use wins. IF/ID holds and is not flushed.
- RUN -> LU_STALL: on load_use, not frozen, no branch, and LOAD_USE_BUBBLES>1. bcnt loads LOAD_USE_BUBBLES-1.
- LU_STALL: bcnt decrements each non-frozen cycle. When bcnt==1, the next state is RUN.
  - Total stall length is exactly LOAD_USE_BUBBLES unfrozen cycles.
- branch_taken in LU_STALL is illegal (EX holds a bubble). It is ignored, and a simulation-only assertion flags it.
- Timeout:
  - An 8-bit wait counter increments while dmem_busy and clears otherwise.
  - When it reaches MEM_TIMEOUT, mem_timeout_err is set. It stays set until reset; the pipeline stays frozen.
  - The counter saturates and does not wrap.
- Reset:
  - State=RUN, bcnt=0, wait counter=0, mem_timeout_err=0, perf counters=0.
  - Outputs then follow the default rules. Asserting reset mid-stall returns to RUN immediately.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt increments every cycle with pc_write==0.
  - perf_flush_cnt increments every cycle with branch_taken acted upon.
  - Both are 32-bit and wrap modulo 2^32.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package core_pkg:
  - hz_state_e enum {RUN, LU_STALL}.
  - REG_ZERO=5'd0.
  - Widths for register index (5) and counters.
- One natural sub-module: hazard_perf_cnt, holding the two counters and instantiated only under HAZARD_PERF_CNT_EN. All other logic stays in hazard_ctrl.

Test Plan:
- ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1, LOAD_USE_BUBBLES=1 -> one cycle pc_write=0, ifid_write=0, idex_flush=1, then defaults.
- Same stimulus with LOAD_USE_BUBBLES=3, and ex_mem_read dropped after cycle 1 -> exactly 3 stall cycles, state returns to RUN.
- branch_taken=1 together with load_use=1 -> pc_write=1, ifid_flush=1, idex_flush=1; no stall follows.
- mem_req=1, dmem_ready=0 for 4 cycles during an LU_STALL with bcnt=2 -> 4 frozen cycles with memwb_flush=1 and bcnt held; then 2 stall cycles.
- dmem_ready held 0 with MEM_TIMEOUT=10 -> mem_timeout_err rises on the 10th busy cycle and stays 1 until reset; reset mid-freeze -> RUN, err=0.
- ex_rd=0 with matching rs1=0, load -> no stall. imem_ready=0 alone -> pc_write=0, ifid_flush=1, idex_write=1.
